// File: rtl/fifo_pkg.sv
// Shared types and pointer helpers for the async FIFO read/write ports.
// Gray/binary conversions take a run-time width so one function serves every pointer size.
package fifo_pkg;

  typedef enum logic [0:0] {
    RD_EMPTY = 1'b0,
    RD_FULL  = 1'b1
  } rd_state_e;

  function automatic logic [31:0] bin2gray(input logic [31:0] bin, input int unsigned width);
    logic [31:0] gray;
    gray = bin ^ (bin >> 1);
    for (int i = 0; i < 32; i++) begin
      if (i >= width) gray[i] = 1'b0;
    end
    return gray;
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] gray, input int unsigned width);
    logic [31:0] gm;
    logic [31:0] bin;
    for (int i = 0; i < 32; i++) begin
      gm[i] = (i < width) ? gray[i] : 1'b0;
    end
    bin[31] = gm[31];
    for (int i = 30; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gm[i];
    end
    return bin;
  endfunction

  // True when the pointer carries exactly one wrap bit above the storage index.
  function automatic bit depth_ok(input int unsigned f_depth, input int unsigned p_size);
    return (p_size >= 2) && (p_size <= 31) && (f_depth == (32'd1 << (p_size - 1)));
  endfunction

endpackage

// File: rtl/fifo_rd_port_if.sv
// Consumer-side handshake bundle of the FIFO read port.
// r_almost_empty exists only when FIFO_RD_ALMOST_EMPTY_EN is defined.
interface fifo_rd_port_if #(
  parameter int unsigned D_SIZE = 16,
  parameter int unsigned P_SIZE = 4
);

  logic [D_SIZE-1:0] r_data;
  logic              r_valid;
  logic              r_ready;
  logic [P_SIZE-1:0] r_level;
  logic              r_err;
`ifdef FIFO_RD_ALMOST_EMPTY_EN
  logic              r_almost_empty;

  modport master (output r_data, r_valid, r_level, r_err, r_almost_empty, input r_ready);
  modport slave  (input r_data, r_valid, r_level, r_err, r_almost_empty, output r_ready);
`else
  modport master (output r_data, r_valid, r_level, r_err, input r_ready);
  modport slave  (input r_data, r_valid, r_level, r_err, output r_ready);
`endif

endinterface

// File: rtl/fifo_rd_ptr.sv
// Read pointer (binary + Gray), storage empty compare and storage-side entry count.
module fifo_rd_ptr
  import fifo_pkg::*;
#(
  parameter int unsigned P_SIZE = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  input  logic [P_SIZE-1:0] wptr_gray_sync,
  output logic [P_SIZE-1:0] rptr_gray,
  output logic [P_SIZE-2:0] mem_raddr,
  output logic              mem_empty,
  output logic [P_SIZE-1:0] mem_cnt
);

  logic [P_SIZE-1:0] rptr_bin_q, rptr_bin_d;
  logic [P_SIZE-1:0] rptr_gray_q, rptr_gray_d;
  logic [P_SIZE-1:0] wptr_bin;
  logic [31:0]       gray_full, wbin_full;
  logic              unused_hi;

  always_comb begin
    rptr_bin_d  = rptr_bin_q + P_SIZE'(inc);
    gray_full   = bin2gray(32'(rptr_bin_d), P_SIZE);
    rptr_gray_d = gray_full[P_SIZE-1:0];
    wbin_full   = gray2bin(32'(wptr_gray_sync), P_SIZE);
    wptr_bin    = wbin_full[P_SIZE-1:0];
  end

  assign unused_hi = ^{gray_full[31:P_SIZE], wbin_full[31:P_SIZE]};

  // Full-width compare: equal index with differing wrap bits means full, not empty.
  assign mem_empty = (rptr_gray_q == wptr_gray_sync);
  assign mem_cnt   = wptr_bin - rptr_bin_q;
  assign mem_raddr = rptr_bin_q[P_SIZE-2:0];
  assign rptr_gray = rptr_gray_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rptr_bin_q  <= '0;
      rptr_gray_q <= '0;
    end else begin
      rptr_bin_q  <= rptr_bin_d;
      rptr_gray_q <= rptr_gray_d;
    end
  end

endmodule

// File: rtl/fifo_rd_port.sv
// Read-domain controller of the async FIFO: registered FWFT output, level and overflow flag.
// Optional macro FIFO_RD_ALMOST_EMPTY_EN adds a registered r_almost_empty output.
module fifo_rd_port
  import fifo_pkg::*;
#(
  parameter int unsigned D_SIZE    = 16,
  parameter int unsigned F_DEPTH   = 8,
  parameter int unsigned P_SIZE    = 4,
  parameter int unsigned AE_THRESH = 2
) (
  input  logic              r_clk,
  input  logic              r_rst,
  input  logic [P_SIZE-1:0] wptr_gray_sync,
  input  logic [D_SIZE-1:0] mem_rdata,
  output logic [P_SIZE-2:0] mem_raddr,
  output logic [P_SIZE-1:0] rptr_gray,
  fifo_rd_port_if.master    rd
);

  localparam bit CfgOk = depth_ok(F_DEPTH, P_SIZE) && (AE_THRESH <= F_DEPTH);
  localparam logic [P_SIZE-1:0] DepthCnt = P_SIZE'(F_DEPTH);

  if (!CfgOk) begin : gen_cfg_check
    $fatal(1, "fifo_rd_port: F_DEPTH must be 2**(P_SIZE-1) and AE_THRESH <= F_DEPTH");
  end

  rd_state_e         state_q, state_d;
  logic [D_SIZE-1:0] r_data_q, r_data_d;
  logic              err_q, err_d;
  logic              load;
  logic              mem_empty;
  logic [P_SIZE-1:0] mem_cnt;

  fifo_rd_ptr #(
    .P_SIZE(P_SIZE)
  ) u_rd_ptr (
    .clk           (r_clk),
    .rst           (r_rst),
    .inc           (load),
    .wptr_gray_sync(wptr_gray_sync),
    .rptr_gray     (rptr_gray),
    .mem_raddr     (mem_raddr),
    .mem_empty     (mem_empty),
    .mem_cnt       (mem_cnt)
  );

  always_comb begin
    load    = !mem_empty && ((state_q == RD_EMPTY) || rd.r_ready);
    state_d = state_q;
    unique case (state_q)
      RD_EMPTY: if (load) state_d = RD_FULL;
      RD_FULL:  if (!load && rd.r_ready) state_d = RD_EMPTY;
      default:  state_d = RD_EMPTY;
    endcase
    r_data_d = load ? mem_rdata : r_data_q;
    // A count above depth can only come from a corrupted write pointer; keep it latched.
    err_d    = err_q || (mem_cnt > DepthCnt);
  end

  always_ff @(posedge r_clk) begin
    if (r_rst) begin
      state_q  <= RD_EMPTY;
      r_data_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      r_data_q <= r_data_d;
      err_q    <= err_d;
    end
  end

  assign rd.r_data  = r_data_q;
  assign rd.r_valid = (state_q == RD_FULL);
  assign rd.r_level = mem_cnt + P_SIZE'(rd.r_valid);
  assign rd.r_err   = err_q;

`ifdef FIFO_RD_ALMOST_EMPTY_EN
  logic [P_SIZE-1:0] level_d;
  logic              ae_q, ae_d;

  // Next-state level against the current write pointer.
  always_comb begin
    level_d = mem_cnt - P_SIZE'(load) + P_SIZE'(state_d == RD_FULL);
    ae_d    = (level_d <= P_SIZE'(AE_THRESH));
  end

  always_ff @(posedge r_clk) begin
    if (r_rst) ae_q <= 1'b1;
    else       ae_q <= ae_d;
  end

  assign rd.r_almost_empty = ae_q;
`endif

endmodule

// File: tb/tb_fifo_rd_port.sv
// Self-checking bench for fifo_rd_port: behavioural storage/write pointer plus a data scoreboard.
module tb_fifo_rd_port;

  localparam int unsigned D_SIZE    = 16;
  localparam int unsigned F_DEPTH   = 8;
  localparam int unsigned P_SIZE    = 4;
  localparam int unsigned AE_THRESH = 2;

  logic              r_clk = 1'b0;
  logic              r_rst;
  logic [P_SIZE-1:0] wbin;
  logic [P_SIZE-1:0] wptr_gray_sync;
  logic [D_SIZE-1:0] mem_rdata;
  logic [P_SIZE-2:0] mem_raddr;
  logic [P_SIZE-1:0] rptr_gray;
  logic [D_SIZE-1:0] mem [F_DEPTH];

  logic [D_SIZE-1:0] exp_q[$];
  logic [P_SIZE-1:0] popped;
  int checks   = 0;
  int failures = 0;

  fifo_rd_port_if #(.D_SIZE(D_SIZE), .P_SIZE(P_SIZE)) rd ();

  fifo_rd_port #(
    .D_SIZE   (D_SIZE),
    .F_DEPTH  (F_DEPTH),
    .P_SIZE   (P_SIZE),
    .AE_THRESH(AE_THRESH)
  ) dut (
    .r_clk         (r_clk),
    .r_rst         (r_rst),
    .wptr_gray_sync(wptr_gray_sync),
    .mem_rdata     (mem_rdata),
    .mem_raddr     (mem_raddr),
    .rptr_gray     (rptr_gray),
    .rd            (rd)
  );

  always #5 r_clk = ~r_clk;

  assign wptr_gray_sync = wbin ^ (wbin >> 1);
  assign mem_rdata      = mem[mem_raddr];

  task automatic push(input logic [D_SIZE-1:0] d);
    mem[wbin[P_SIZE-2:0]] = d;
    wbin = wbin + 1'b1;
    exp_q.push_back(d);
  endtask

  task automatic apply_reset();
    r_rst       = 1'b1;
    wbin        = '0;
    rd.r_ready  = 1'b0;
    repeat (2) @(posedge r_clk);
    @(negedge r_clk);
    r_rst  = 1'b0;
    popped = '0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (rd.r_valid !== 1'b0) begin failures++;
      $display("FAIL reset_valid got=%b want=0", rd.r_valid); end
    checks++; if (rd.r_level !== 4'd0) begin failures++;
      $display("FAIL reset_level got=%0d want=0", rd.r_level); end
    checks++; if (rptr_gray !== 4'd0) begin failures++;
      $display("FAIL reset_rptr_gray got=%h want=0", rptr_gray); end
    checks++; if (rd.r_err !== 1'b0) begin failures++;
      $display("FAIL reset_err got=%b want=0", rd.r_err); end
    checks++; if (rd.r_data !== 16'h0000) begin failures++;
      $display("FAIL reset_data got=%h want=0000", rd.r_data); end
  endtask

  task automatic test_single();
    push(16'hA5A5);
    @(negedge r_clk);
    checks++; if (rd.r_valid !== 1'b1) begin failures++;
      $display("FAIL single_valid got=%b want=1", rd.r_valid); end
    checks++; if (rd.r_level !== 4'd1) begin failures++;
      $display("FAIL single_level got=%0d want=1", rd.r_level); end
    rd.r_ready = 1'b1;
    checks++; if (rd.r_data !== exp_q[0]) begin failures++;
      $display("FAIL single_data got=%h want=%h", rd.r_data, exp_q[0]); end
    void'(exp_q.pop_front());
    popped++;
    @(negedge r_clk);
    rd.r_ready = 1'b0;
    checks++; if (rd.r_valid !== 1'b0) begin failures++;
      $display("FAIL single_drain_valid got=%b want=0", rd.r_valid); end
    checks++; if (rptr_gray !== 4'd1) begin failures++;
      $display("FAIL single_rptr_gray got=%h want=1", rptr_gray); end
  endtask

  task automatic test_backpressure();
    rd.r_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge r_clk);
      push(16'h1000 + 16'(i));
    end
    repeat (2) @(negedge r_clk);
    checks++; if (rd.r_valid !== 1'b1) begin failures++;
      $display("FAIL bp_valid got=%b want=1", rd.r_valid); end
    checks++; if (rd.r_data !== 16'h1000) begin failures++;
      $display("FAIL bp_hold_data got=%h want=1000", rd.r_data); end
    checks++; if (rd.r_level !== 4'd3) begin failures++;
      $display("FAIL bp_level got=%0d want=3", rd.r_level); end
    for (int i = 0; i < 3; i++) begin
      rd.r_ready = 1'b1;
      checks++; if (rd.r_valid !== 1'b1) begin failures++;
        $display("FAIL bp_pop_valid[%0d] got=%b want=1", i, rd.r_valid); end
      checks++; if (rd.r_data !== exp_q[0]) begin failures++;
        $display("FAIL bp_pop_data[%0d] got=%h want=%h", i, rd.r_data, exp_q[0]); end
      void'(exp_q.pop_front());
      popped++;
      @(negedge r_clk);
    end
    rd.r_ready = 1'b0;
    checks++; if (rd.r_valid !== 1'b0) begin failures++;
      $display("FAIL bp_end_valid got=%b want=0", rd.r_valid); end
    checks++; if (rd.r_level !== 4'd0) begin failures++;
      $display("FAIL bp_end_level got=%0d want=0", rd.r_level); end
  endtask

  task automatic test_wrap();
    int writes = 0;
    int reads  = 0;
    logic [P_SIZE-1:0] exp_gray;
    for (int cyc = 0; cyc < 400 && (writes < 20 || exp_q.size() > 0); cyc++) begin
      @(negedge r_clk);
      checks++; if (rd.r_level !== P_SIZE'(wbin - popped)) begin failures++;
        $display("FAIL wrap_level cyc=%0d got=%0d want=%0d", cyc, rd.r_level, wbin - popped); end
      if (writes < 20 && P_SIZE'(wbin - popped) < P_SIZE'(F_DEPTH) && ($urandom % 4) != 0) begin
        push(16'h2000 + 16'(writes));
        writes++;
      end
      rd.r_ready = (($urandom % 3) != 0);
      if (rd.r_valid && rd.r_ready) begin
        checks++;
        if (exp_q.size() == 0) begin failures++;
          $display("FAIL wrap_unexpected got=%h want=none", rd.r_data);
        end else begin
          if (rd.r_data !== exp_q[0]) begin failures++;
            $display("FAIL wrap_data read=%0d got=%h want=%h", reads, rd.r_data, exp_q[0]); end
          void'(exp_q.pop_front());
        end
        popped++;
        reads++;
      end
    end
    @(negedge r_clk);
    rd.r_ready = 1'b0;
    checks++; if (reads != 20 || exp_q.size() != 0) begin failures++;
      $display("FAIL wrap_drain got=%0d reads want=20", reads); end
    exp_gray = popped ^ (popped >> 1);
    checks++; if (rptr_gray !== exp_gray) begin failures++;
      $display("FAIL wrap_rptr_gray got=%h want=%h", rptr_gray, exp_gray); end
  endtask

  task automatic test_error();
    apply_reset();
    checks++; if (rd.r_err !== 1'b0) begin failures++;
      $display("FAIL err_pre got=%b want=0", rd.r_err); end
    wbin = 4'd10;
    @(negedge r_clk);
    checks++; if (rd.r_err !== 1'b1) begin failures++;
      $display("FAIL err_set got=%b want=1", rd.r_err); end
    wbin = 4'd1;
    repeat (3) @(negedge r_clk);
    checks++; if (rd.r_err !== 1'b1) begin failures++;
      $display("FAIL err_sticky got=%b want=1", rd.r_err); end
    apply_reset();
    checks++; if (rd.r_err !== 1'b0) begin failures++;
      $display("FAIL err_clear got=%b want=0", rd.r_err); end
  endtask

`ifdef FIFO_RD_ALMOST_EMPTY_EN
  task automatic test_almost_empty();
    apply_reset();
    checks++; if (rd.r_almost_empty !== 1'b1) begin failures++;
      $display("FAIL ae_reset got=%b want=1", rd.r_almost_empty); end
    for (int i = 0; i < 3; i++) begin
      push(16'h3000 + 16'(i));
      @(negedge r_clk);
    end
    @(negedge r_clk);
    checks++; if (rd.r_level !== 4'd3 || rd.r_almost_empty !== 1'b0) begin failures++;
      $display("FAIL ae_level3 got=%0d/%b want=3/0", rd.r_level, rd.r_almost_empty); end
    rd.r_ready = 1'b1;
    checks++; if (rd.r_data !== exp_q[0]) begin failures++;
      $display("FAIL ae_data got=%h want=%h", rd.r_data, exp_q[0]); end
    void'(exp_q.pop_front());
    popped++;
    @(negedge r_clk);
    rd.r_ready = 1'b0;
    checks++; if (rd.r_level !== 4'd2 || rd.r_almost_empty !== 1'b1) begin failures++;
      $display("FAIL ae_level2 got=%0d/%b want=2/1", rd.r_level, rd.r_almost_empty); end
    push(16'h3003);
    @(negedge r_clk);
    checks++; if (rd.r_level !== 4'd3 || rd.r_almost_empty !== 1'b0) begin failures++;
      $display("FAIL ae_back3 got=%0d/%b want=3/0", rd.r_level, rd.r_almost_empty); end
  endtask
`endif

  initial begin
    r_rst      = 1'b1;
    wbin       = '0;
    rd.r_ready = 1'b0;
    popped     = '0;
    for (int i = 0; i < F_DEPTH; i++) mem[i] = '0;
    test_reset();
    test_single();
    test_backpressure();
    test_wrap();
    test_error();
`ifdef FIFO_RD_ALMOST_EMPTY_EN
    test_almost_empty();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
